// File: rtl/keycode_tracker.sv
// keycode_tracker: queues HID key press/release events and maintains a
// compacted, duplicate-free array of currently held keys (slot 0 = oldest).
// A small event FIFO decouples the producer from a scan/shift FSM that
// applies one event at a time; the slot array itself is the registered
// output, so the frame-rate consumer always sees a consistent snapshot.
module keycode_tracker #(
    parameter int FIFO_DEPTH = 4,
    parameter int NUM_SLOTS  = 6,
    parameter int KEY_W      = 8
) (
    input  logic             frame_clk,
    input  logic             Reset,
    input  logic             ev_valid,
    output logic             ev_ready,
    input  logic [KEY_W-1:0] ev_code,
    input  logic             ev_press,
    input  logic             clear_all,
    output logic [KEY_W-1:0] keycode [0:NUM_SLOTS-1],
    output logic [2:0]       key_count,
    output logic             overflow,
    output logic             busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(FIFO_DEPTH);
    localparam logic [2:0]       SLOTS_MAX = 3'(NUM_SLOTS);
    // Codes 0x00..0x03 are "no key" and HID error indications, never real keys.
    localparam logic [KEY_W-1:0] FIRST_KEY = KEY_W'(4);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    // Event queue storage
    logic [KEY_W-1:0] r_fifo_code  [0:FIFO_DEPTH-1];
    logic             r_fifo_press [0:FIFO_DEPTH-1];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;

    // FSM and slot array state
    state_t           r_state;
    logic [KEY_W-1:0] r_cur_code;
    logic             r_cur_press;
    logic [2:0]       r_idx;
    logic [KEY_W-1:0] r_slot [0:NUM_SLOTS-1];
    logic [2:0]       r_count;
    logic             r_overflow;

    // Combinational controls
    state_t           w_state_nxt;
    logic [2:0]       w_idx_nxt;
    logic [2:0]       w_idx_p1;
    logic             w_push;
    logic             w_pop;
    logic             w_ins;
    logic             w_ovf_set;
    logic             w_shift_move;
    logic             w_shift_done;
    logic [KEY_W-1:0] w_head_code;
    logic [KEY_W-1:0] w_slot_at_idx;
    logic [KEY_W-1:0] w_slot_above;

    assign ev_ready    = (r_level < FULL_LVL) & ~clear_all;
    assign w_push      = ev_valid & ev_ready;
    assign w_head_code = r_fifo_code[r_rd_ptr];
    assign w_idx_p1    = r_idx + 3'd1;

    assign keycode   = r_slot;
    assign key_count = r_count;
    assign overflow  = r_overflow;
    assign busy      = (r_state != ST_IDLE) | (r_level != '0);

    // Select the slot under the scan index and the one just above it.
    always_comb begin
        w_slot_at_idx = '0;
        w_slot_above  = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_slot_at_idx = (r_idx    == 3'(i)) ? r_slot[i] : w_slot_at_idx;
            w_slot_above  = (w_idx_p1 == 3'(i)) ? r_slot[i] : w_slot_above;
        end
    end

    // Next-state and slot-update decisions for the scan/shift FSM.
    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_pop        = 1'b0;
        w_ins        = 1'b0;
        w_ovf_set    = 1'b0;
        w_shift_move = 1'b0;
        w_shift_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_level != '0) begin
                    w_pop     = 1'b1;
                    w_idx_nxt = 3'd0;
                    if (w_head_code < FIRST_KEY) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_SCAN;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (r_idx == r_count) begin
                    // Walked past every held key without a match.
                    if (r_cur_press) begin
                        if (r_count < SLOTS_MAX) begin
                            w_ins = 1'b1;
                        end else begin
                            w_ovf_set = 1'b1;
                        end
                    end else begin
                        w_ins = 1'b0;
                    end
                    w_state_nxt = ST_IDLE;
                end else if (w_slot_at_idx == r_cur_code) begin
                    if (r_cur_press) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_SHIFT;
                    end
                end else begin
                    w_idx_nxt = w_idx_p1;
                end
            end
            ST_SHIFT: begin
                if (w_idx_p1 < r_count) begin
                    w_shift_move = 1'b1;
                    w_idx_nxt    = w_idx_p1;
                end else begin
                    w_shift_done = 1'b1;
                    w_state_nxt  = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = 3'd0;
            end
        endcase
    end

    // Event queue: write on accepted push, advance read on FSM pop.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_code[i]  <= '0;
                r_fifo_press[i] <= 1'b0;
            end
        end else if (clear_all) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_fifo_code[r_wr_ptr]  <= ev_code;
                r_fifo_press[r_wr_ptr] <= ev_press;
                r_wr_ptr               <= r_wr_ptr + PTR_W'(1);
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // FSM state, scan index and the event currently being applied.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= ST_IDLE;
            r_idx       <= 3'd0;
            r_cur_code  <= '0;
            r_cur_press <= 1'b0;
        end else if (clear_all) begin
            r_state     <= ST_IDLE;
            r_idx       <= 3'd0;
            r_cur_code  <= '0;
            r_cur_press <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            if (w_pop) begin
                r_cur_code  <= w_head_code;
                r_cur_press <= r_fifo_press[r_rd_ptr];
            end else begin
                r_cur_code  <= r_cur_code;
                r_cur_press <= r_cur_press;
            end
        end
    end

    // Slot array, count and sticky overflow. A shift step moves the upper
    // neighbour down and clears its old place in the same edge, so no
    // intermediate state ever holds the same key twice.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_count    <= 3'd0;
            r_overflow <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_slot[i] <= '0;
            end
        end else if (clear_all) begin
            r_count    <= 3'd0;
            r_overflow <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_slot[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (w_ins && (r_count == 3'(i))) begin
                    r_slot[i] <= r_cur_code;
                end else if (w_shift_move && (r_idx == 3'(i))) begin
                    r_slot[i] <= w_slot_above;
                end else if ((w_shift_move && (w_idx_p1 == 3'(i))) ||
                             (w_shift_done && (r_idx == 3'(i)))) begin
                    r_slot[i] <= '0;
                end else begin
                    r_slot[i] <= r_slot[i];
                end
            end
            if (w_ins) begin
                r_count <= r_count + 3'd1;
            end else if (w_shift_done) begin
                r_count <= r_count - 3'd1;
            end else begin
                r_count <= r_count;
            end
            r_overflow <= r_overflow | w_ovf_set;
        end
    end

endmodule

// File: tb/tb_keycode_tracker.sv
// Testbench for keycode_tracker: directed scenarios plus random traffic,
// checked against a list-based model of the held-key set.
module tb_keycode_tracker;

    logic       frame_clk = 1'b0;
    logic       Reset     = 1'b1;
    logic       ev_valid  = 1'b0;
    logic       ev_ready;
    logic [7:0] ev_code   = 8'h00;
    logic       ev_press  = 1'b0;
    logic       clear_all = 1'b0;
    logic [7:0] keycode [0:5];
    logic [2:0] key_count;
    logic       overflow;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    // Model: ordered list of held keys plus sticky overflow.
    logic [7:0] m_keys[$];
    int         m_ovf = 0;

    keycode_tracker #(.FIFO_DEPTH(4), .NUM_SLOTS(6), .KEY_W(8)) dut (
        .frame_clk(frame_clk), .Reset(Reset),
        .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_code(ev_code), .ev_press(ev_press),
        .clear_all(clear_all), .keycode(keycode),
        .key_count(key_count), .overflow(overflow), .busy(busy)
    );

    always #5 frame_clk = ~frame_clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void m_clear();
        m_keys.delete();
        m_ovf = 0;
    endfunction

    function automatic void m_apply(input logic [7:0] c, input logic p);
        int f;
        f = -1;
        if (c < 8'h04) return;
        foreach (m_keys[i]) if (m_keys[i] == c) f = i;
        if (p) begin
            if (f < 0) begin
                if (m_keys.size() < 6) m_keys.push_back(c);
                else m_ovf = 1;
            end
        end else if (f >= 0) begin
            m_keys.delete(f);
        end
    endfunction

    // Per-cycle monitor: duplicate-free, zero tail, and model match when idle.
    always @(negedge frame_clk) begin
        if (mon_en && !Reset) begin
            int dup;
            dup = 0;
            for (int i = 0; i < 6; i++)
                for (int j = i + 1; j < 6; j++)
                    if (keycode[i] != 8'h00 && keycode[i] == keycode[j]) dup = 1;
            chk("no_duplicate", dup, 0);
            for (int i = 0; i < 6; i++)
                if (i >= int'(key_count)) chk("tail_zero", keycode[i], 0);
            if (!busy) begin
                chk("model_count", key_count, m_keys.size());
                chk("model_overflow", overflow, m_ovf);
                for (int i = 0; i < 6; i++)
                    chk("model_slot", keycode[i], (i < m_keys.size()) ? m_keys[i] : 0);
            end
        end
    end

    // One clock of stimulus: drive at negedge, note acceptance, update model at posedge.
    task automatic step(input logic v, input logic [7:0] c, input logic p,
                        input logic clr, output logic acc);
        @(negedge frame_clk);
        ev_valid = v; ev_code = c; ev_press = p; clear_all = clr;
        #1;
        if (clr) chk("ready_during_clear", ev_ready, 0);
        acc = v && ev_ready;
        @(posedge frame_clk);
        if (clr) m_clear();
        else if (acc) m_apply(c, p);
        #2;
        ev_valid = 1'b0; clear_all = 1'b0;
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0, a);
    endtask

    task automatic send(input logic [7:0] c, input logic p);
        logic a;
        a = 1'b0;
        for (int t = 0; t < 50 && !a; t++) step(1'b1, c, p, 1'b0, a);
        chk("send_accepted", a, 1);
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 80 && busy; t++) idle(1);
        chk("idle_timeout", busy, 0);
    endtask

    task automatic chk_array(input string name, input logic [47:0] exp, input int cnt);
        logic [47:0] e;
        e = exp;
        for (int i = 0; i < 6; i++) chk(name, keycode[i], e[47 - 8*i -: 8]);
        chk(name, key_count, cnt);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic a;
        logic [7:0] rel [0:7];
        int first_stall;
        int accepted;

        // Reset values
        #12;
        chk_array("reset_array", 48'h0, 0);
        chk("reset_ready", ev_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_overflow", overflow, 0);
        @(negedge frame_clk);
        Reset = 1'b0;
        mon_en = 1'b1;

        // 1: press on empty array lands two edges after the push
        step(1'b1, 8'h04, 1'b1, 1'b0, a);
        chk("t1_accept", a, 1);
        chk("t1_count_edge0", key_count, 0);
        idle(1);
        chk("t1_count_edge1", key_count, 0);
        idle(1);
        chk("t1_slot0", keycode[0], 8'h04);
        chk("t1_count", key_count, 1);
        chk("t1_busy", busy, 0);

        // 2: release from the middle compacts the array
        send(8'h07, 1'b1);
        send(8'h1A, 1'b1);
        wait_idle();
        send(8'h07, 1'b0);
        wait_idle();
        chk_array("t2_array", 48'h04_1A_00_00_00_00, 2);

        // 3: seven distinct presses fill six slots and flag overflow
        step(1'b0, 8'h00, 1'b0, 1'b1, a);
        for (int k = 4; k <= 10; k++) send(8'(k), 1'b1);
        wait_idle();
        chk_array("t3_full", 48'h04_05_06_07_08_09, 6);
        chk("t3_overflow", overflow, 1);
        send(8'h04, 1'b1);
        wait_idle();
        chk_array("t3_dup_press", 48'h04_05_06_07_08_09, 6);

        // 4: back-to-back releases with ev_valid held high
        rel = '{8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h04};
        first_stall = -1;
        accepted = 0;
        for (int t = 0; t < 200 && accepted < 8; t++) begin
            step(1'b1, rel[accepted], 1'b0, 1'b0, a);
            if (a) accepted++;
            else if (first_stall < 0) first_stall = accepted;
        end
        chk("t4_accepted", accepted, 8);
        chk("t4_accepts_before_stall", first_stall, 5);
        wait_idle();
        chk("t4_count", key_count, 0);
        chk("t4_overflow_sticky", overflow, 1);

        // 5: codes 0x00/0x01 are dropped
        send(8'h05, 1'b1);
        send(8'h00, 1'b1);
        send(8'h01, 1'b1);
        send(8'h03, 1'b0);
        wait_idle();
        chk_array("t5_array", 48'h05_00_00_00_00_00, 1);

        // 6: clear_all while shifting with three events queued
        send(8'h04, 1'b1);
        send(8'h06, 1'b1);
        wait_idle();
        send(8'h05, 1'b0);
        send(8'h07, 1'b1);
        send(8'h08, 1'b1);
        send(8'h09, 1'b1);
        chk("t6_busy_before_clear", busy, 1);
        step(1'b0, 8'h00, 1'b0, 1'b1, a);
        chk_array("t6_array", 48'h0, 0);
        chk("t6_overflow", overflow, 0);
        chk("t6_busy", busy, 0);
        idle(2);
        chk("t6_count_stays", key_count, 0);

        // Reset asserted mid-SCAN takes effect without a clock edge
        for (int k = 4; k <= 7; k++) send(8'(k), 1'b1);
        wait_idle();
        send(8'h08, 1'b1);
        idle(2);
        chk("rst_busy_before", busy, 1);
        #3;
        Reset = 1'b1;
        m_clear();
        #1;
        chk_array("rst_array", 48'h0, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", ev_ready, 1);
        chk("rst_overflow", overflow, 0);
        @(negedge frame_clk);
        Reset = 1'b0;
        send(8'h0C, 1'b1);
        idle(2);
        chk_array("post_rst", 48'h0C_00_00_00_00_00, 1);

        // Random traffic
        for (int t = 0; t < 600; t++) begin
            step(($urandom % 3) != 0, 8'($urandom_range(0, 12)),
                 ($urandom % 3) != 0, ($urandom % 60) == 0, a);
        end
        wait_idle();
        chk("rand_final_count", key_count, m_keys.size());

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
